memory_stage: RTL

Pipeline stage directly downstream of the execute stage. It consumes the effective address or ALU result, the store data, funct3 and the load/store flags, and performs at most one data-memory access per instruction over a req/ack bus. It produces the register write-back value: aligned and extended load data, or the ALU result passed through. It uses the same prev_done/stall_prev and done_next/next_stall handshake as the other pipeline stages.

---
 rtl/memory_stage.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: performs one data-memory access per load/store and builds the write-back value.
// Latency: 1 cycle capture-to-done for non-memory ops; 2+ cycles for memory ops (1 + bus wait cycles).
// Backpressure: stall_prev held while an access is in flight or a finished result waits on next_stall.
module memory_stage #(
  localparam int ADDR_WIDTH              = 32,
  localparam int DATA_WIDTH              = 32,
  localparam int REGISTER_INDEXING_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               stall_prev,
  input  logic                               prev_done,
  input  logic                               next_stall,
  output logic                               done_next,
  input  logic [ADDR_WIDTH-1:0]              program_count_in,
  input  logic                               program_count_valid_in,
  input  logic                               load_in,
  input  logic                               store_in,
  input  logic                               opcode_legal_in,
  input  logic [2:0]                         funct_3_in,
  input  logic                               funct_3_valid_in,
  input  logic [DATA_WIDTH-1:0]              result_data_in,
  input  logic                               result_data_valid_in,
  input  logic [DATA_WIDTH-1:0]              memory_store_data_in,
  input  logic                               memory_store_data_valid_in,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
  input  logic                               write_register_valid_in,
  output logic [ADDR_WIDTH-1:0]              program_count_out,
  output logic                               program_count_valid_out,
  output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
  output logic                               write_register_valid_out,
  output logic                               opcode_legal_out,
  output logic [DATA_WIDTH-1:0]              write_data_out,
  output logic                               write_data_valid_out,
  output logic                               misaligned_out,
  output logic                               size_illegal_out,
  output logic                               mem_req,
  output logic                               mem_we,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  output logic [DATA_WIDTH/8-1:0]            mem_wstrb,
  input  logic                               mem_ack,
  input  logic [DATA_WIDTH-1:0]              mem_rdata
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [LANES-1:0] BYTE_MASK = LANES'(1);
  localparam logic [LANES-1:0] HALF_MASK = LANES'(3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Captured copy of the instruction; everything downstream works from this.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]              pc;
    logic                               pc_vld;
    logic                               load;
    logic                               store;
    logic                               legal;
    logic [2:0]                         f3;
    logic [DATA_WIDTH-1:0]              addr;
    logic [DATA_WIDTH-1:0]              sdata;
    logic [REGISTER_INDEXING_WIDTH-1:0] wr;
    logic                               wr_vld;
  } instr_t;

  state_t state, state_d;
  instr_t instr_q;

  logic [DATA_WIDTH-1:0] write_data_q;
  logic                  write_data_valid_q;
  logic                  misaligned_q;
  logic                  size_illegal_q;

  logic transfer_prev;
  logic transfer_next;

  logic in_is_mem;
  logic in_f3_legal;
  logic in_misaligned;
  logic in_size_illegal;
  logic in_go_access;

  logic [1:0]            lane;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_value;

  // Classify the incoming instruction: legality, alignment and whether a bus access is needed.
  always_comb begin
    in_is_mem   = load_in || store_in;
    in_f3_legal = 1'b0;
    case (funct_3_in)
      3'b000, 3'b001, 3'b010: in_f3_legal = 1'b1;
      3'b100, 3'b101:         in_f3_legal = load_in && !store_in;
      default:                in_f3_legal = 1'b0;
    endcase
    in_size_illegal = in_is_mem && !in_f3_legal;
    // Only meaningful once the size is known to be legal.
    in_misaligned = in_is_mem && in_f3_legal &&
                    (((funct_3_in[1:0] == 2'b01) && result_data_in[0]) ||
                     ((funct_3_in[1:0] == 2'b10) && (result_data_in[1:0] != 2'b00)));
    in_go_access = in_is_mem && result_data_valid_in && funct_3_valid_in && in_f3_legal &&
                   !in_misaligned && (!store_in || memory_store_data_valid_in);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; a capture always overrides, since it only happens from IDLE or a draining DONE.
  always_comb begin
    state_d = state;
    if (transfer_prev) begin
      state_d = in_go_access ? ACCESS : DONE;
    end else begin
      case (state)
        IDLE:    state_d = IDLE;
        ACCESS:  state_d = mem_ack ? DONE : ACCESS;
        DONE:    state_d = transfer_next ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake and bus outputs, all decoded from state and the captured instruction.
  always_comb begin
    done_next     = !rst && (state == DONE);
    transfer_next = done_next && !next_stall;
    stall_prev    = rst || ((state != IDLE) && !((state == DONE) && transfer_next));
    transfer_prev = prev_done && !stall_prev;
    mem_req       = !rst && (state == ACCESS);
    mem_we        = instr_q.store;
    mem_addr      = {instr_q.addr[ADDR_WIDTH-1:2], 2'b00};
    mem_wdata     = instr_q.sdata;
    mem_wstrb     = '0;
    if (instr_q.store) begin
      case (instr_q.f3[1:0])
        2'b00: begin
          mem_wstrb = BYTE_MASK << instr_q.addr[1:0];
          mem_wdata = {LANES{instr_q.sdata[7:0]}};
        end
        2'b01: begin
          mem_wstrb = HALF_MASK << instr_q.addr[1:0];
          mem_wdata = {(LANES/2){instr_q.sdata[15:0]}};
        end
        default: begin
          mem_wstrb = '1;
          mem_wdata = instr_q.sdata;
        end
      endcase
    end
  end

  // Align the returned word and sign/zero-extend according to the captured funct3.
  always_comb begin
    lane    = instr_q.addr[1:0];
    ld_byte = mem_rdata[{lane, 3'b000} +: 8];
    ld_half = mem_rdata[{instr_q.addr[1], 4'b0000} +: 16];
    case (instr_q.f3[1:0])
      2'b00:   load_value = {{(DATA_WIDTH-8){!instr_q.f3[2] && ld_byte[7]}}, ld_byte};
      2'b01:   load_value = {{(DATA_WIDTH-16){!instr_q.f3[2] && ld_half[15]}}, ld_half};
      default: load_value = mem_rdata;
    endcase
  end

  // Capture on an upstream transfer; fill in the load result on the acknowledging edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q.pc_vld     <= 1'b0;
      instr_q.wr_vld     <= 1'b0;
      write_data_valid_q <= 1'b0;
      misaligned_q       <= 1'b0;
      size_illegal_q     <= 1'b0;
    end else if (transfer_prev) begin
      instr_q.pc         <= program_count_in;
      instr_q.pc_vld     <= program_count_valid_in;
      instr_q.load       <= load_in;
      instr_q.store      <= store_in;
      instr_q.legal      <= opcode_legal_in;
      instr_q.f3         <= funct_3_in;
      instr_q.addr       <= result_data_in;
      instr_q.sdata      <= memory_store_data_in;
      instr_q.wr         <= write_register_in;
      instr_q.wr_vld     <= write_register_valid_in;
      write_data_q       <= result_data_in;
      // Memory ops only become valid once a load completes on the bus.
      write_data_valid_q <= !in_is_mem && result_data_valid_in;
      misaligned_q       <= in_misaligned;
      size_illegal_q     <= in_size_illegal;
    end else if ((state == ACCESS) && mem_ack && instr_q.load && !instr_q.store) begin
      write_data_q       <= load_value;
      write_data_valid_q <= 1'b1;
    end
  end

  assign program_count_out        = instr_q.pc;
  assign program_count_valid_out  = instr_q.pc_vld;
  assign write_register_out       = instr_q.wr;
  assign write_register_valid_out = instr_q.wr_vld;
  assign opcode_legal_out         = instr_q.legal;
  assign write_data_out           = write_data_q;
  assign write_data_valid_out     = write_data_valid_q;
  assign misaligned_out           = misaligned_q;
  assign size_illegal_out         = size_illegal_q;

endmodule
